iic_m_xfer_seq: RTL and testbench

IIC_M_XFER_SEQ -- requirements
Module: iic_m_xfer_seq

---
 rtl/iic_m_xfer_seq.sv | 166 ++++++++++++++++
 tb/tb_iic_m_xfer_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/iic_m_xfer_seq.sv
// rtl/iic_m_xfer_seq.sv - I2C master register read/write sequencer driving a byte-level PHY
`timescale 1ns/1ps
module iic_m_xfer_seq #(
  parameter int U_DLY = 1
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_len,
  input  logic       wdat_valid,
  output logic       wdat_ready,
  input  logic [7:0] wdat,
  output logic       rdat_valid,
  output logic [7:0] rdat,
  output logic       usr_wvalid,
  input  logic       usr_wready,
  output logic [3:0] usr_wcmd,
  output logic [7:0] usr_wdata,
  input  logic       usr_rvalid,
  input  logic [7:0] usr_rdata,
  input  logic       dgb_err_sack,
  input  logic       dbg_err_abt,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  // U_DLY only describes simulation timing; the synthesized logic is delay-free.
  if (U_DLY < 0) begin : g_neg_u_dly
  end

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEV_W   = 4'd1;
  localparam logic [3:0] S_REG     = 4'd2;
  localparam logic [3:0] S_WDATA   = 4'd3;
  localparam logic [3:0] S_DEV_R   = 4'd4;
  localparam logic [3:0] S_RDATA   = 4'd5;
  localparam logic [3:0] S_WAIT_RD = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0] r_state;
  logic       r_rnw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_tx_cnt;
  logic [7:0] r_rx_cnt;
  logic [1:0] r_err;

  logic       w_fire;
  logic       w_err_in;
  logic       w_active;
  logic       w_tx_last;
  logic       w_rx_fire;
  logic [7:0] w_len_eff;

  assign w_fire    = usr_wvalid & usr_wready;
  assign w_err_in  = dgb_err_sack | dbg_err_abt;
  assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_tx_last = (r_tx_cnt <= 8'd1);
  assign w_rx_fire = usr_rvalid & ((r_state == S_RDATA) || (r_state == S_WAIT_RD));
  // A zero-length read still fetches one byte.
  assign w_len_eff = (req_rnw && (req_len == 8'd0)) ? 8'd1 : req_len;

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE) || (r_state == S_ERR);
  assign err        = (r_state == S_ERR) ? r_err : 2'b00;
  assign rdat_valid = w_rx_fire;
  assign rdat       = w_rx_fire ? usr_rdata : 8'h00;

  always_comb begin
    usr_wvalid = 1'b0;
    usr_wcmd   = 4'b0000;
    usr_wdata  = 8'h00;
    wdat_ready = 1'b0;
    case (r_state)
      S_DEV_W: begin
        usr_wvalid = 1'b1;
        usr_wcmd   = 4'b0001;
        usr_wdata  = {r_dev, 1'b0};
      end
      S_REG: begin
        usr_wvalid = 1'b1;
        usr_wcmd   = (!r_rnw && (r_tx_cnt == 8'd0)) ? 4'b0010 : 4'b0000;
        usr_wdata  = r_reg;
      end
      S_WDATA: begin
        usr_wvalid = wdat_valid;
        usr_wcmd   = w_tx_last ? 4'b0010 : 4'b0000;
        usr_wdata  = wdat;
        wdat_ready = usr_wready;
      end
      S_DEV_R: begin
        usr_wvalid = 1'b1;
        usr_wcmd   = 4'b0001;
        usr_wdata  = {r_dev, 1'b1};
      end
      S_RDATA: begin
        usr_wvalid = 1'b1;
        usr_wcmd   = w_tx_last ? 4'b1110 : 4'b0100;
        usr_wdata  = 8'h00;
      end
      default: begin
        usr_wvalid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rnw    <= 1'b0;
      r_dev    <= 7'h00;
      r_reg    <= 8'h00;
      r_tx_cnt <= 8'h00;
      r_rx_cnt <= 8'h00;
      r_err    <= 2'b00;
    end else begin
      if (w_active && w_err_in) begin
        r_state <= S_ERR;
        r_err   <= {dbg_err_abt, dgb_err_sack};
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid) begin
              r_rnw    <= req_rnw;
              r_dev    <= req_dev_addr;
              r_reg    <= req_reg_addr;
              r_tx_cnt <= w_len_eff;
              r_rx_cnt <= req_rnw ? w_len_eff : 8'd0;
              r_err    <= 2'b00;
              r_state  <= S_DEV_W;
            end
          end
          S_DEV_W: if (w_fire) r_state <= S_REG;
          S_REG: begin
            if (w_fire) begin
              if (r_rnw)                  r_state <= S_DEV_R;
              else if (r_tx_cnt == 8'd0)  r_state <= S_DONE;
              else                        r_state <= S_WDATA;
            end
          end
          S_WDATA, S_RDATA: begin
            if (w_fire) begin
              r_tx_cnt <= (r_tx_cnt == 8'd0) ? 8'd0 : r_tx_cnt - 8'd1;
              if (w_tx_last) r_state <= (r_state == S_WDATA) ? S_DONE : S_WAIT_RD;
            end
          end
          S_DEV_R: if (w_fire) r_state <= S_RDATA;
          S_WAIT_RD: begin
            // Finish on the edge that consumes the last byte, keeping done one cycle behind it.
            if ((r_rx_cnt == 8'd0) || ((r_rx_cnt == 8'd1) && usr_rvalid)) r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
      if (w_rx_fire && (r_rx_cnt != 8'd0)) r_rx_cnt <= r_rx_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_iic_m_xfer_seq.sv
// tb/tb_iic_m_xfer_seq.sv - randomized self-checking bench for iic_m_xfer_seq
`timescale 1ns/1ps
module tb_iic_m_xfer_seq;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr, req_len;
  logic       wdat_valid, wdat_ready;
  logic [7:0] wdat;
  logic       rdat_valid;
  logic [7:0] rdat;
  logic       usr_wvalid, usr_wready;
  logic [3:0] usr_wcmd;
  logic [7:0] usr_wdata;
  logic       usr_rvalid;
  logic [7:0] usr_rdata;
  logic       dgb_err_sack, dbg_err_abt;
  logic       busy, done;
  logic [1:0] err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] wq[$];

  always #5 clk_sys = ~clk_sys;

  iic_m_xfer_seq #(.U_DLY(1)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat),
    .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_wcmd(usr_wcmd), .usr_wdata(usr_wdata),
    .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata),
    .dgb_err_sack(dgb_err_sack), .dbg_err_abt(dbg_err_abt),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_rnw = 0; req_dev_addr = 0; req_reg_addr = 0; req_len = 0;
    wdat_valid = 0; wdat = 0; usr_wready = 0; usr_rvalid = 0; usr_rdata = 0;
    dgb_err_sack = 0; dbg_err_abt = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_wdat_ready"}, wdat_ready, 0);
    chk({pfx, "_rdat_valid"}, rdat_valid, 0);
    chk({pfx, "_usr_wvalid"}, usr_wvalid, 0);
    chk({pfx, "_usr_wcmd"}, usr_wcmd, 0);
    chk({pfx, "_usr_wdata"}, usr_wdata, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  // mode: 0 plain, 1 hold usr_wready low 5 cycles on the REG word,
  //       2 slave NACK after first data byte, 3 abort during read, 4 reset during read
  task automatic run_xfer(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] len, input int mode);
    logic [11:0] exp_w[$];
    logic [11:0] got[$];
    int n, wi, pend, nrx, acc_t, last_ev, done_t, inj_t, hold;
    logic acc, fin, inj, wd_took, prev_stall, rst_hit;
    logic [12:0] prev_word;
    logic [1:0] done_err;

    n = (rnw && len == 0) ? 1 : int'(len);
    exp_w.push_back({4'h1, dev, 1'b0});
    if (rnw) begin
      exp_w.push_back({4'h0, rg});
      exp_w.push_back({4'h1, dev, 1'b1});
      for (int i = 0; i < n; i++) exp_w.push_back({(i == n - 1) ? 4'hE : 4'h4, 8'h00});
    end else begin
      exp_w.push_back({(len == 0) ? 4'h2 : 4'h0, rg});
      for (int i = 0; i < n; i++) exp_w.push_back({(i == n - 1) ? 4'h2 : 4'h0, wq[i]});
    end

    wi = 0; pend = 0; nrx = 0; acc_t = 0; last_ev = 0; done_t = -1; inj_t = -1; hold = 0;
    acc = 0; fin = 0; inj = 0; wd_took = 0; prev_stall = 0; rst_hit = 0;
    prev_word = 0; done_err = 0;

    for (int t = 0; t < 1000 && !fin; t++) begin
      @(posedge clk_sys); #1;
      if (t == 0) begin
        req_valid = 1; req_rnw = rnw; req_dev_addr = dev; req_reg_addr = rg; req_len = len;
      end else if (acc) begin
        req_valid = 0;
      end
      if (mode == 1 && got.size() == 1 && hold < 5) begin
        usr_wready = 0; hold++;
      end else begin
        usr_wready = ($urandom_range(0, 3) != 0);
      end
      if (!wdat_valid || wd_took) wdat_valid = (!rnw && wi < n) && ($urandom_range(0, 2) != 0);
      wdat = (!rnw && wi < n) ? wq[wi] : 8'h00;
      wd_took = 0;
      usr_rvalid = (pend > 0) && !inj && ($urandom_range(0, 1) == 1);
      usr_rdata = 8'($urandom);
      dgb_err_sack = 0; dbg_err_abt = 0;
      if ((mode == 2 || mode == 3) && !inj && got.size() >= 3) begin
        if (mode == 2) dgb_err_sack = 1; else dbg_err_abt = 1;
        inj = 1; inj_t = t;
      end
      if (mode == 4 && got.size() >= 4) begin
        rst_n = 0; #1;
        chk_reset_outputs("midrst");
        @(posedge clk_sys); #1;
        rst_n = 1; usr_rvalid = 0; wdat_valid = 0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_sys);
          chk("midrst_no_done", done, 0);
        end
        rst_hit = 1;
        break;
      end

      @(negedge clk_sys);
      if (!acc && req_valid && req_ready) begin
        acc = 1; acc_t = t;
      end else if (acc && t == acc_t + 1) begin
        chk("first_wvalid", usr_wvalid, 1);
        chk("busy_active", busy, 1);
      end
      if (prev_stall && !(inj && t == inj_t + 1))
        chk("stall_hold", {usr_wvalid, usr_wcmd, usr_wdata}, prev_word);
      prev_stall = usr_wvalid && !usr_wready;
      prev_word  = {usr_wvalid, usr_wcmd, usr_wdata};
      if (wdat_ready)
        chk("wdat_ready_window", (!rnw && got.size() >= 2 && got.size() < n + 2), 1);
      if (usr_wvalid && usr_wready) begin
        got.push_back({usr_wcmd, usr_wdata});
        last_ev = t;
        if (usr_wcmd[2]) pend++;
      end
      if (wdat_valid && wdat_ready) begin
        wi++; wd_took = 1;
      end
      if (usr_rvalid) begin
        pend--; nrx++; last_ev = t;
        chk("rdat_valid", rdat_valid, 1);
        chk("rdat", rdat, usr_rdata);
      end else if (rdat_valid) begin
        chk("rdat_spurious", rdat_valid, 0);
      end
      if (inj && t == inj_t + 1) begin
        chk("err_wvalid_drop", usr_wvalid, 0);
        chk("err_done", done, 1);
        chk("err_code", err, (mode == 2) ? 32'd1 : 32'd2);
      end
      if (done) begin
        fin = 1; done_t = t; done_err = err;
      end
    end

    if (!rst_hit) begin
      chk("done_seen", fin, 1);
      if (mode <= 1) begin
        chk("word_count", got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
          chk($sformatf("word%0d", i), got[i], exp_w[i]);
        chk("done_err", done_err, 0);
        chk("done_latency", done_t, last_ev + 1);
        if (rnw) chk("rx_count", nrx, n);
      end
      @(posedge clk_sys); #1;
      usr_rvalid = 0; wdat_valid = 0; dgb_err_sack = 0; dbg_err_abt = 0;
      @(negedge clk_sys);
      chk("ready_after", req_ready, 1);
      chk("busy_after", busy, 0);
      chk("done_after", done, 0);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1;

    wq = {8'hA5, 8'h5A};
    run_xfer(1'b0, 7'h50, 8'h10, 8'd2, 0);
    wq.delete();
    run_xfer(1'b1, 7'h50, 8'h20, 8'd3, 0);
    run_xfer(1'b0, 7'h50, 8'h05, 8'd0, 0);
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(8'($urandom));
    run_xfer(1'b0, 7'h2A, 8'h77, 8'd3, 1);
    run_xfer(1'b1, 7'h13, 8'h44, 8'd0, 0);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    run_xfer(1'b0, 7'h50, 8'h30, 8'd4, 2);
    run_xfer(1'b1, 7'h61, 8'h31, 8'd3, 3);
    run_xfer(1'b1, 7'h50, 8'h20, 8'd4, 4);
    wq = {8'hC3, 8'h3C};
    run_xfer(1'b0, 7'h50, 8'h11, 8'd2, 0);

    for (int r = 0; r < 20; r++) begin
      wq.delete();
      for (int i = 0; i < 6; i++) wq.push_back(8'($urandom));
      run_xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom_range(0, 5)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
